// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions. Holds the opcode values, the
//               instruction field positions, the default fetch address width
//               and the fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int INSTR_W        = 16;

  // Opcodes that downstream decode acts on; all others are treated as no-ops
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_AND    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_LOAD   = 4'b0101;
  localparam logic [3:0] OP_STORE  = 4'b0110;
  localparam logic [3:0] OP_BRANCH = 4'b1000;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  // Instruction field positions (LSB of each field)
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_SLOT = 2'd2,
    S_HALT      = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[OPC_LSB +: FIELD_W] == OP_HALT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction memory request/acknowledge bus. The fetch unit
//               is the master, the instruction memory is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry FIFO holding fetched {instruction, pc} entries.
//               The head entry is read straight from storage so it stays
//               stable while not popped. Callers never push when full or
//               pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DATA_W = 24
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire logic [DATA_W-1:0] push_data,
  input  wire logic              pop,
  output logic                   valid,
  output logic [1:0]             count,
  output logic [DATA_W-1:0]      head_data
);
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q,  count_d;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  // State registers; reset clears contents so the presented fields read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid     = (count_q != 2'd0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Issues one outstanding request at a
//               time, captures returned words with their pc, presents the
//               decoded fields and stops on HALT.
//               Build option FETCH_BUF_EN: 2-entry output buffer (1 instr per
//               cycle at zero wait); otherwise a single output register.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  instr_fetch_if.master     imem,
  input  wire logic         stall,
  output logic              instr_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [7:0]        imm8,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);
  localparam int ENTRY_W = INSTR_W + ADDR_W;
`ifdef FETCH_BUF_EN
  localparam logic [1:0] CAPACITY = 2'd2;
`else
  localparam logic [1:0] CAPACITY = 2'd1;
`endif

  fetch_state_e       state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               halted_q, halted_d;

  logic               push, pop, buf_valid;
  logic [1:0]         buf_count, count_next;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [INSTR_W-1:0] head_instr;

  // An ack only counts while our request is on the bus
  assign push       = req_q & imem.imem_ack;
  assign push_entry = {imem.imem_rdata, pc_q};
  assign pop        = buf_valid & ~stall;
  assign count_next = buf_count + 2'(push) - 2'(pop);

`ifdef FETCH_BUF_EN
  fetch_fifo #(.DATA_W(ENTRY_W)) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (buf_valid),
    .count     (buf_count),
    .head_data (head_entry)
  );
`else
  logic [ENTRY_W-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;

  // Single output slot; a request is only issued when it will be free
  always_comb begin
    out_d       = push ? push_entry : out_q;
    out_valid_d = push | (out_valid_q & ~pop);
  end

  // Output slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign buf_valid  = out_valid_q;
  assign buf_count  = {1'b0, out_valid_q};
  assign head_entry = out_q;
`endif

  // Fetch sequencing: request, wait for a free slot, or stop on HALT
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (push) begin
          pc_d = pc_q + ADDR_W'(1);
          if (is_halt(imem.imem_rdata)) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (count_next < CAPACITY) begin
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT_SLOT;
          end
        end
      end
      S_WAIT_SLOT: begin
        if (count_next < CAPACITY) begin
          state_d = S_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  // Control registers; reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  assign head_instr  = head_entry[ENTRY_W-1 -: INSTR_W];
  assign instr_valid = buf_valid;
  assign opcode      = head_instr[OPC_LSB +: FIELD_W];
  assign rd          = head_instr[RD_LSB  +: FIELD_W];
  assign rs1         = head_instr[RS1_LSB +: FIELD_W];
  assign rs2         = head_instr[RS2_LSB +: FIELD_W];
  assign imm8        = head_instr[IMM_LSB +: IMM_W];
  assign pc_out      = head_entry[ADDR_W-1:0];
  assign halted      = halted_q;
endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning the instruction memory word-address width.
REQ-002 The module SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port imem_req, output, 1 bit: fetch request.
REQ-006 The module SHALL have port imem_addr, output, ADDR_W bits: fetch word address.
REQ-007 The module SHALL have port imem_ack, input, 1 bit: memory returns data this cycle.
REQ-008 The module SHALL have port imem_rdata, input, 16 bits: instruction word, valid when imem_ack=1.
REQ-009 The module SHALL have port stall, input, 1 bit: downstream not ready.
REQ-010 The module SHALL have port instr_valid, output, 1 bit: decoded fields valid.
REQ-011 The module SHALL have ports opcode[3:0], rd[3:0], rs1[3:0], rs2[3:0] and imm8[7:0], all outputs, holding instr[15:12], [11:8], [7:4], [3:0] and [7:0] respectively.
REQ-012 The module SHALL have port pc_out, output, ADDR_W bits: address of the presented instruction.
REQ-013 The module SHALL have port halted, output, 1 bit: the fetch has stopped on HALT.

Function
REQ-014 States SHALL be: IDLE -> REQ (first cycle after reset) -> REQ/WAIT_SLOT on each ack -> HALT (terminal); WAIT_SLOT -> REQ when a slot frees.
REQ-015 In REQ, imem_req=1 and imem_addr=pc SHALL be held stable until imem_ack=1; at most one request is outstanding.
REQ-016 imem_ack SHALL be ignored while imem_req=0 or rst=1.
REQ-017 On ack, the data and pc SHALL be captured; instr_valid=1 from the next cycle (1-cycle latency from ack to output).
REQ-018 pc SHALL increment by 1 per ack and wrap from all-ones to 0 without any flag.
REQ-019 An output SHALL be consumed in a cycle when instr_valid=1 and stall=0; while stall=1, every output holds its value.
REQ-020 A new request SHALL issue only when (buffered entries + outstanding) < capacity, so data returned is never dropped.
REQ-021 Capturing opcode 4'b1111 (HALT) SHALL stop further requests; the HALT word is still presented, halted=1 the cycle after capture, and the module stays in HALT until rst.
REQ-022 Opcodes 0000-0110 and 1000 SHALL pass through unmodified; other non-HALT opcodes SHALL also be presented unchanged, and downstream decode treats them as no-ops.

Reset
REQ-023 On rst=1 at a clock edge: imem_req=0, instr_valid=0, halted=0, pc=RESET_PC, all fields 0, buffer emptied, and any outstanding request abandoned.
REQ-024 rst SHALL dominate ack, stall and HALT in the same cycle.

Configuration
REQ-025 Macro FETCH_BUF_EN SHALL control buffering. When defined: 2-entry FIFO, requests continue while capacity allows, and a zero-wait memory with stall=0 sustains 1 instruction/cycle. When undefined: capacity 1, a request issues only when the output is empty or being consumed, giving 1 instruction per 2 cycles at zero wait.

Structure
REQ-026 A shared package cpu_pkg SHALL hold the opcode localparams (including OP_HALT=4'b1111), instruction field bit positions and the default ADDR_W.
REQ-027 The 2-entry buffer SHALL be a sub-module fetch_fifo, instantiated only under FETCH_BUF_EN.

Verification
REQ-028 Reset release with zero-wait ack: imem_addr=0 in cycle 1, instr_valid=1 in cycle 2 with pc_out=0; buffered mode gives pc_out 0,1,2 on consecutive cycles.
REQ-029 Ack delayed 3 cycles: imem_addr stays 0x05 and imem_req stays 1 for all 4 cycles, and exactly one instruction is delivered.
REQ-030 stall=1 for 5 cycles with the buffer full: outputs stay frozen, imem_req=0, and no instruction is lost or duplicated after release.
REQ-031 pc=0xFF fetch: pc_out=0xFF, and the next fetch address is 0x00.
REQ-032 Word 0xF000 at pc 0x10: presented with opcode=F, halted=1 the next cycle, imem_req stays 0 forever, and rst restarts at RESET_PC.
REQ-033 rst asserted with a request outstanding and ack arriving in the same cycle: the data is dropped, instr_valid=0, and the next request is at RESET_PC.
